mcu_spi: RTL

MCU_SPI -- requirements
Module: mcu_spi

---
 rtl/mcu_spi.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mcu_spi.sv
// SPI slave bridging an MCU into the clk32 domain: the first byte of each
// transaction selects a target, the following bytes are strobed out to it.
module mcu_spi #(
  parameter logic [7:0] TARGET_SYS = 8'd1,
  parameter logic [7:0] TARGET_HID = 8'd2,
  parameter logic [7:0] TARGET_OSD = 8'd3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       spi_csn,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [7:0] mcu_reply,
  output logic       mcu_start,
  output logic       mcu_sys_strobe,
  output logic       mcu_hid_strobe,
  output logic       mcu_osd_strobe,
  output logic [7:0] mcu_data
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TARGET  = 2'd1,
    ST_FIRST   = 2'd2,
    ST_PAYLOAD = 2'd3
  } state_t;

  logic       csn_meta_r, csn_sync_r, csn_prev_r;
  logic       sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic       mosi_meta_r, mosi_sync_r;
  logic [1:0] fill_r;
  logic       armed_r;
  state_t     state_r, state_next_s;
  logic [2:0] bit_cnt_r;
  logic [7:0] rx_shift_r, tx_shift_r, target_r, data_r;
  logic       miso_r, start_r, sys_r, hid_r, osd_r;

  logic       start_s, active_s, sclk_rise_s, sclk_fall_s, byte_done_s;
  logic       hit_sys_s, hit_hid_s, hit_osd_s, hit_any_s;
  logic [7:0] rx_byte_s;

  // Two-stage synchronizers plus one history stage for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      csn_meta_r  <= 1'b1;
      csn_sync_r  <= 1'b1;
      csn_prev_r  <= 1'b1;
      sclk_meta_r <= 1'b0;
      sclk_sync_r <= 1'b0;
      sclk_prev_r <= 1'b0;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
    end else begin
      csn_meta_r  <= spi_csn;
      csn_sync_r  <= csn_meta_r;
      csn_prev_r  <= csn_sync_r;
      sclk_meta_r <= spi_sclk;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
      mosi_meta_r <= spi_mosi;
      mosi_sync_r <= mosi_meta_r;
    end
  end

  // The synchronizer reset value of csn=1 is not a real observation, so a
  // start is only accepted once a genuinely sampled csn=1 has been seen.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fill_r  <= 2'd0;
      armed_r <= 1'b0;
    end else begin
      if (fill_r != 2'd2) begin
        fill_r <= fill_r + 2'd1;
      end else begin
        fill_r <= fill_r;
      end
      if ((fill_r == 2'd2) && csn_sync_r) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  assign start_s     = armed_r & csn_prev_r & ~csn_sync_r;
  assign active_s    = ~csn_sync_r & (state_r != ST_IDLE);
  assign sclk_rise_s = active_s & sclk_sync_r & ~sclk_prev_r;
  assign sclk_fall_s = active_s & ~sclk_sync_r & sclk_prev_r;
  assign byte_done_s = sclk_rise_s & (bit_cnt_r == 3'd7);
  assign rx_byte_s   = {rx_shift_r[6:0], mosi_sync_r};
  assign hit_sys_s   = (target_r == TARGET_SYS);
  assign hit_hid_s   = (target_r == TARGET_HID);
  assign hit_osd_s   = (target_r == TARGET_OSD);
  assign hit_any_s   = hit_sys_s | hit_hid_s | hit_osd_s;

  // Byte-state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Byte-state transitions; csn high always returns to IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_next_s = ST_TARGET;
        else         state_next_s = ST_IDLE;
      end
      ST_TARGET: begin
        if (csn_sync_r)       state_next_s = ST_IDLE;
        else if (byte_done_s) state_next_s = ST_FIRST;
        else                  state_next_s = ST_TARGET;
      end
      ST_FIRST: begin
        if (csn_sync_r)       state_next_s = ST_IDLE;
        else if (byte_done_s) state_next_s = ST_PAYLOAD;
        else                  state_next_s = ST_FIRST;
      end
      ST_PAYLOAD: begin
        if (csn_sync_r) state_next_s = ST_IDLE;
        else            state_next_s = ST_PAYLOAD;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Shift datapath, MISO output and the one-cycle strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt_r  <= 3'd0;
      rx_shift_r <= 8'h00;
      tx_shift_r <= 8'h00;
      target_r   <= 8'h00;
      data_r     <= 8'h00;
      miso_r     <= 1'b0;
      start_r    <= 1'b0;
      sys_r      <= 1'b0;
      hid_r      <= 1'b0;
      osd_r      <= 1'b0;
    end else begin
      start_r <= 1'b0;
      sys_r   <= 1'b0;
      hid_r   <= 1'b0;
      osd_r   <= 1'b0;
      if (csn_sync_r) begin
        bit_cnt_r  <= 3'd0;
        rx_shift_r <= 8'h00;
        miso_r     <= 1'b0;
      end else if (start_s) begin
        bit_cnt_r  <= 3'd0;
        rx_shift_r <= 8'h00;
        tx_shift_r <= 8'h00;
        miso_r     <= 1'b0;
      end else if (sclk_rise_s) begin
        rx_shift_r <= rx_byte_s;
        bit_cnt_r  <= bit_cnt_r + 3'd1;
        if (byte_done_s) begin
          tx_shift_r <= mcu_reply;
          if (state_r == ST_TARGET) begin
            target_r <= rx_byte_s;
          end else begin
            data_r  <= rx_byte_s;
            sys_r   <= hit_sys_s;
            hid_r   <= hit_hid_s;
            osd_r   <= hit_osd_s;
            start_r <= (state_r == ST_FIRST) & hit_any_s;
          end
        end else begin
          tx_shift_r <= tx_shift_r;
        end
      end else if (sclk_fall_s) begin
        // Counter already points at the next bit slot, so 7-count is MSB-first.
        miso_r <= tx_shift_r[3'd7 - bit_cnt_r];
      end else begin
        miso_r <= miso_r;
      end
    end
  end

  assign spi_miso       = miso_r;
  assign mcu_start      = start_r;
  assign mcu_sys_strobe = sys_r;
  assign mcu_hid_strobe = hid_r;
  assign mcu_osd_strobe = osd_r;
  assign mcu_data       = data_r;

endmodule
